// File: rtl/stopwatch_ctrl.sv
// Front-panel control for the BCD stopwatch: debounces start/stop and lap buttons
// and runs the run/lap/pause/idle control FSM that drives the counter.

module stopwatch_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned DB_W      = 20
) (
  input  logic CLK,
  input  logic CLR,
  input  logic btn,
  output logic press
);

  logic            s1;
  logic            s2;
  logic            db;
  logic            db_d;
  logic [DB_W-1:0] cnt;

  // Synchronize, then accept a new level only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      db_d  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      db_d  <= db;
      press <= db & ~db_d;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

module stopwatch_ctrl #(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned DB_W      = 20,
  parameter int unsigned CLR_PULSE = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       BTN_SS,
  input  logic       BTN_LAP,
  output logic       RUN,
  output logic       LAP_HOLD,
  output logic       CLR_REQ_N,
  output logic [1:0] STATE
);

  localparam int unsigned CP_W = (CLR_PULSE > 1) ? $clog2(CLR_PULSE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_LAP   = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  logic            ss;
  logic            lap;
  state_t          state_q;
  state_t          state_d;
  logic            run_q;
  logic            run_d;
  logic            lap_hold_q;
  logic            lap_hold_d;
  logic            clr_n_q;
  logic            clr_n_d;
  logic [CP_W-1:0] clr_cnt_q;
  logic [CP_W-1:0] clr_cnt_d;

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_ss (
    .CLK   (CLK),
    .CLR   (CLR),
    .btn   (BTN_SS),
    .press (ss)
  );

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_lap (
    .CLK   (CLK),
    .CLR   (CLR),
    .btn   (BTN_LAP),
    .press (lap)
  );

  // State and registered outputs.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      lap_hold_q <= 1'b0;
      clr_n_q    <= 1'b1;
      clr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      lap_hold_q <= lap_hold_d;
      clr_n_q    <= clr_n_d;
      clr_cnt_q  <= clr_cnt_d;
    end
  end

  // Next state; outputs decoded from the next state so they change on the same edge as STATE.
  always_comb begin
    state_d   = state_q;
    clr_n_d   = clr_n_q;
    clr_cnt_d = clr_cnt_q;

    // An active clear pulse counts down independently of FSM activity.
    if (!clr_n_q) begin
      if (clr_cnt_q == '0) begin
        clr_n_d = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt_q - CP_W'(1);
      end
    end

    // Start/stop always wins over a lap press in the same cycle.
    case (state_q)
      S_IDLE: begin
        if (ss) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss)       state_d = S_PAUSE;
        else if (lap) state_d = S_LAP;
      end
      S_LAP: begin
        if (ss)       state_d = S_PAUSE;
        else if (lap) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ss) begin
          state_d = S_RUN;
        end else if (lap) begin
          state_d   = S_IDLE;
          clr_n_d   = 1'b0;
          clr_cnt_d = CP_W'(CLR_PULSE - 1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    run_d      = (state_d == S_RUN) || (state_d == S_LAP);
    lap_hold_d = (state_d == S_LAP);
  end

  assign RUN       = run_q;
  assign LAP_HOLD  = lap_hold_q;
  assign CLR_REQ_N = clr_n_q;
  assign STATE     = state_q;

endmodule
